wb_ffram_adapter: RTL and testbench
===================================

// Module: wb_ffram_adapter
// PURPOSE
// Wishbone classic slave front end for the flip-flop RAM. Converts single WB cycles into
// RAM wb_en/r_en/bit_en/addr/d_in strobes, registers read data and generates ack. RAM write
// zeroes unmasked bits, so partial (byte-select) writes are done as read-modify-write here.
// Sits between the WB interconnect slave port and the RAM macro; address decode is upstream.
// PARAMETERS
// WORD_NUM  256               number of RAM words
// WORD_W    32                word width in bits; multiple of 8
// AD_WIDTH  $clog2(WORD_NUM)  RAM word-address width
// SEL_W     WORD_W/8          byte-select width
// PORTS
// clk         in   1         clock
// rst         in   1         synchronous, active-high reset
// wbs_cyc_i   in   1         WB cycle valid
// wbs_stb_i   in   1         WB strobe
// wbs_we_i    in   1         1 = write, 0 = read
// wbs_sel_i   in   SEL_W     byte selects
// wbs_adr_i   in   32        byte address; word index = adr[AD_WIDTH+1:2], rest ignored
// wbs_dat_i   in   WORD_W    write data
// wbs_ack_o   out  1         single-cycle acknowledge
// wbs_dat_o   out  WORD_W    read data, valid while ack=1
// ram_wb_en   out  1         RAM access enable
// ram_r_en    out  1         1 = RAM read, 0 = RAM write
// ram_bit_en  out  WORD_W    RAM bit enable
// ram_addr    out  AD_WIDTH  RAM word address
// ram_d_in    out  WORD_W    RAM write data
// ram_d_out   in   WORD_W    RAM combinational read data
// BEHAVIOUR
// - FSM states: IDLE, READ, WRITE, ACK. Reset -> IDLE; ack=0, dat_o=0, ram_wb_en=0,
//   ram_r_en=0, ram_bit_en=0, ram_addr=0, ram_d_in=0; all request regs cleared.
// - IDLE: on cyc&stb, register adr index, we, sel, dat_i. Next state:
//   read -> READ; write sel=all-ones -> WRITE; write sel partial -> READ; write sel=0 -> ACK.
// - READ: ram_wb_en=cyc, ram_r_en=1, bit_en=all ones; ram_d_out captured into rdata reg at
//   the closing edge. Next: read -> ACK; partial write -> WRITE.
// - WRITE: ram_wb_en=cyc, ram_r_en=0, bit_en=all ones,
//   d_in = (dat & selmask) | (rdata & ~selmask), selmask = each sel bit expanded to 8 bits.
//   Full-word write uses dat directly. RAM updates at closing edge. Next: ACK.
// - ACK: ack=1 for exactly one cycle; dat_o = rdata & selmask for reads, 0 for writes. -> IDLE.
// - Latency (stb to ack): read 2 cycles, full write 2, partial write 3, sel=0 write 1.
//   Back-to-back requests: IDLE always spends one cycle; no pipelining.
// - Abort: cyc low in READ/WRITE/ACK -> ram_wb_en forced 0 that cycle, ack suppressed,
//   next state IDLE; no RAM write occurs for aborted WRITE.
// - Outside ACK: dat_o=0, ack=0. Outside READ/WRITE: ram_wb_en=0, bit_en=0, d_in=0.
// - rst mid-transaction: FSM -> IDLE next edge, no ack, no RAM write that cycle.
// - Address wraps mod WORD_NUM via truncation; addr is held stable from IDLE capture to ACK.
// STRUCTURE
// - Package ffram_pkg: typedef enum logic [1:0] wbf_state_t {IDLE,READ,WRITE,ACK};
//   function sel_to_mask(sel) -> byte-expanded bit mask; constant WB_ADR_W = 32.
// - One sub-module: ffram_sel_expand (combinational, SEL_W -> WORD_W mask); FSM, request
//   registers and rdata register live in this module. Top-level instantiates this + RAM.
// TESTING (bench instantiates adapter + RAM, WORD_NUM=256)
// - Full write adr=0x10 dat=0xDEADBEEF sel=F, then read adr=0x10 -> ack 2 cycles after
//   stb, dat_o=0xDEADBEEF.
// - Word 4 = 0x11223344; write sel=0b0010 dat=0xAABBCCDD -> 3-cycle ack; read -> 0x1122CC44.
// - Read word 4 with sel=0b1001 -> dat_o=0x11000044; write with sel=0 -> ack 1 cycle, word
//   unchanged.
// - Drop cyc in WRITE cycle of a full write to 0x20 -> no ack, word at 0x20 still 0.
// - rst asserted during READ of partial write -> IDLE, no ack, outputs 0, memory cleared.
// - Address adr=0x400 (index 256) aliases to word 0; back-to-back reads each ack once.

Source files
------------

// File: rtl/ffram_pkg.sv
// ffram_pkg
//   Shared types and helpers for the Wishbone front end of the flip-flop RAM.
//   - wbf_state_t : adapter FSM state encoding
//   - WB_ADR_W    : Wishbone byte-address width
//   - MAX_SEL_W   : widest byte-select vector the mask helper supports
//   - sel_to_mask : expands each byte-select bit into an 8-bit lane mask
package ffram_pkg;

  localparam int WB_ADR_W  = 32;
  localparam int MAX_SEL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } wbf_state_t;

  // Byte lane i of the result is all ones when sel[i] is set.
  function automatic logic [8*MAX_SEL_W-1:0] sel_to_mask(input logic [MAX_SEL_W-1:0] sel);
    logic [8*MAX_SEL_W-1:0] m;
    m = {(8*MAX_SEL_W){1'b0}};
    for (int i = 0; i < MAX_SEL_W; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_ffram_adapter_if.sv
// wb_ffram_adapter_if
//   Wishbone classic slave-port bundle between the interconnect and the adapter.
//   Master drives cyc/stb/we/sel/adr/dat_i; slave returns ack and dat_o.
//   Parameter WORD_W : data width in bits (multiple of 8).
interface wb_ffram_adapter_if
  import ffram_pkg::*;
#(
  parameter int WORD_W = 32
);
  localparam int SEL_W = WORD_W / 8;

  logic                wbs_cyc_i;
  logic                wbs_stb_i;
  logic                wbs_we_i;
  logic [SEL_W-1:0]    wbs_sel_i;
  logic [WB_ADR_W-1:0] wbs_adr_i;
  logic [WORD_W-1:0]   wbs_dat_i;
  logic                wbs_ack_o;
  logic [WORD_W-1:0]   wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/ffram_sel_expand.sv
// ffram_sel_expand
//   Combinational byte-select to bit-mask expansion.
//   sel_i  [SEL_W]  : byte selects
//   mask_o [WORD_W] : each select bit replicated across its byte lane
module ffram_sel_expand
  import ffram_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEL_W  = WORD_W / 8
) (
  input  logic [SEL_W-1:0]  sel_i,
  output logic [WORD_W-1:0] mask_o
);

  // Widen to the helper's fixed width, then keep only the lanes this word has.
  assign mask_o = WORD_W'(sel_to_mask(MAX_SEL_W'(sel_i)));

endmodule

// File: rtl/wb_ffram_adapter.sv
// wb_ffram_adapter
//   Wishbone classic slave front end for the flip-flop RAM. Each WB cycle becomes
//   RAM strobes; read data is registered and returned with a one-cycle ack. The RAM
//   zeroes unmasked bits on write, so partial byte writes are read-modify-write.
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   wbs         : Wishbone slave bundle (cyc/stb/we/sel/adr/dat_i -> ack/dat_o)
//   ram_wb_en   : RAM access enable
//   ram_r_en    : 1 = RAM read, 0 = RAM write
//   ram_bit_en  : RAM bit enable
//   ram_addr    : RAM word address (held from capture to ack)
//   ram_d_in    : RAM write data
//   ram_d_out   : RAM combinational read data
module wb_ffram_adapter
  import ffram_pkg::*;
#(
  parameter int WORD_NUM = 256,
  parameter int WORD_W   = 32,
  parameter int AD_WIDTH = $clog2(WORD_NUM),
  parameter int SEL_W    = WORD_W / 8
) (
  input  logic                clk,
  input  logic                rst,
  wb_ffram_adapter_if.slave   wbs,
  output logic                ram_wb_en,
  output logic                ram_r_en,
  output logic [WORD_W-1:0]   ram_bit_en,
  output logic [AD_WIDTH-1:0] ram_addr,
  output logic [WORD_W-1:0]   ram_d_in,
  input  logic [WORD_W-1:0]   ram_d_out
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_READ  = READ;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_ACK   = ACK;

  logic [1:0]          state_q,  state_d;
  logic [AD_WIDTH-1:0] adr_q,    adr_d;
  logic                we_q,     we_d;
  logic [SEL_W-1:0]    sel_q,    sel_d;
  logic [WORD_W-1:0]   dat_q,    dat_d;
  logic [WORD_W-1:0]   rdata_q,  rdata_d;

  logic [WORD_W-1:0]   selmask_s;
  logic                req_s;
  logic                sel_full_s;
  logic                sel_none_s;
  logic                ack_s;
  logic [WORD_W-1:0]   dat_o_s;
  logic                adr_unused_s;

  // Byte offset and bits above the RAM depth do not take part in decoding.
  assign adr_unused_s = ^{wbs.wbs_adr_i[WB_ADR_W-1:AD_WIDTH+2], wbs.wbs_adr_i[1:0]};

  ffram_sel_expand #(
    .WORD_W (WORD_W),
    .SEL_W  (SEL_W)
  ) u_sel_expand (
    .sel_i  (sel_q),
    .mask_o (selmask_s)
  );

  assign req_s      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign sel_full_s = &wbs.wbs_sel_i;
  assign sel_none_s = ~(|wbs.wbs_sel_i);

  // Next-state and request-capture logic.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          adr_d = wbs.wbs_adr_i[AD_WIDTH+1:2];
          we_d  = wbs.wbs_we_i;
          sel_d = wbs.wbs_sel_i;
          dat_d = wbs.wbs_dat_i;
          if (!wbs.wbs_we_i) begin
            state_d = S_READ;
          end else if (sel_full_s) begin
            state_d = S_WRITE;
          end else if (sel_none_s) begin
            state_d = S_ACK;   // nothing to write, just acknowledge
          end else begin
            state_d = S_READ;  // partial write: fetch old word first
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          rdata_d = ram_d_out;
          state_d = we_q ? S_WRITE : S_ACK;
        end
      end
      S_WRITE: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      adr_q   <= {AD_WIDTH{1'b0}};
      we_q    <= 1'b0;
      sel_q   <= {SEL_W{1'b0}};
      dat_q   <= {WORD_W{1'b0}};
      rdata_q <= {WORD_W{1'b0}};
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM strobes and WB response decoded from the current state. Enables are
  // gated by cyc (abort) and rst so neither an aborted nor a reset cycle writes.
  always_comb begin
    ram_wb_en  = 1'b0;
    ram_r_en   = 1'b0;
    ram_bit_en = {WORD_W{1'b0}};
    ram_d_in   = {WORD_W{1'b0}};
    ack_s      = 1'b0;
    dat_o_s    = {WORD_W{1'b0}};
    case (state_q)
      S_READ: begin
        ram_wb_en  = wbs.wbs_cyc_i & ~rst;
        ram_r_en   = 1'b1;
        ram_bit_en = {WORD_W{1'b1}};
      end
      S_WRITE: begin
        ram_wb_en  = wbs.wbs_cyc_i & ~rst;
        ram_r_en   = 1'b0;
        ram_bit_en = {WORD_W{1'b1}};
        if (&sel_q) begin
          ram_d_in = dat_q;
        end else begin
          ram_d_in = (dat_q & selmask_s) | (rdata_q & ~selmask_s);
        end
      end
      S_ACK: begin
        ack_s = wbs.wbs_cyc_i & ~rst;
        if (ack_s && !we_q) begin
          dat_o_s = rdata_q & selmask_s;
        end else begin
          dat_o_s = {WORD_W{1'b0}};
        end
      end
      default: begin
        ack_s = 1'b0;
      end
    endcase
  end

  assign wbs.wbs_ack_o = ack_s;
  assign wbs.wbs_dat_o = dat_o_s;
  assign ram_addr      = adr_q;

endmodule

// File: tb/tb_wb_ffram_adapter.sv
module tb_wb_ffram_adapter;

  logic        clk;
  logic        rst;
  logic        ram_wb_en;
  logic        ram_r_en;
  logic [31:0] ram_bit_en;
  logic [7:0]  ram_addr;
  logic [31:0] ram_d_in;
  logic [31:0] ram_d_out;

  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  wb_ffram_adapter_if #(.WORD_W(32)) wb ();

  wb_ffram_adapter #(
    .WORD_NUM (256),
    .WORD_W   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wbs        (wb.slave),
    .ram_wb_en  (ram_wb_en),
    .ram_r_en   (ram_r_en),
    .ram_bit_en (ram_bit_en),
    .ram_addr   (ram_addr),
    .ram_d_in   (ram_d_in),
    .ram_d_out  (ram_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flip-flop RAM model: write stores only enabled bits, others become zero.
  assign ram_d_out = mem[ram_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (ram_wb_en && !ram_r_en) begin
      mem[ram_addr] <= ram_d_in & ram_bit_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
  endtask

  // One WB cycle; lat = posedges from stb capture to ack, 0 if no ack in budget.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rd, output int lat);
    bit done;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    lat  = 0;
    rd   = 32'h0;
    done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!done) begin
        @(posedge clk);
        #1;
        if (wb.wbs_ack_o === 1'b1) begin
          lat  = k;
          rd   = wb.wbs_dat_o;
          done = 1'b1;
        end
      end
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", wb.wbs_ack_o); end
    checks++; if (wb.wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat_o: got %h want 0", wb.wbs_dat_o); end
    checks++; if (ram_wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %0b want 0", ram_wb_en); end
    checks++; if (ram_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %0b want 0", ram_r_en); end
    checks++; if (ram_bit_en !== 32'h0) begin errors++; $display("FAIL reset_bit_en: got %h want 0", ram_bit_en); end
    checks++; if (ram_addr !== 8'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
    checks++; if (ram_d_in !== 32'h0) begin errors++; $display("FAIL reset_d_in: got %h want 0", ram_d_in); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL full_write_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL full_write_dat_o: got %h want 0", rd); end
    wb_xfer(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL read_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, 32'h10, 4'hF, 32'h11223344, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word4_init_lat: got %0d want 2", lat); end
    wb_xfer(1'b1, 32'h10, 4'b0010, 32'hAABBCCDD, rd, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL partial_write_lat: got %0d want 3", lat); end
    wb_xfer(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h1122CC44) begin errors++; $display("FAIL partial_readback: got %h want 1122cc44", rd); end
  endtask

  task automatic test_sel_masks();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b0, 32'h10, 4'b1001, 32'h0, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL masked_read_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'h11000044) begin errors++; $display("FAIL masked_read: got %h want 11000044", rd); end
    wb_xfer(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sel0_write_lat: got %0d want 1", lat); end
    wb_xfer(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h1122CC44) begin errors++; $display("FAIL sel0_unchanged: got %h want 1122cc44", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int lat;
    int acks;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = 32'h20;
    wb.wbs_dat_i = 32'h12345678;
    @(posedge clk);
    #1;
    checks++; if (ram_wb_en !== 1'b1) begin errors++; $display("FAIL abort_write_en_before: got %0b want 1", ram_wb_en); end
    @(negedge clk);
    idle_bus();
    #1;
    checks++; if (ram_wb_en !== 1'b0) begin errors++; $display("FAIL abort_write_en_forced: got %0b want 0", ram_wb_en); end
    acks = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    wb_xfer(1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_no_write: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_sel_i = 4'b0100;
    wb.wbs_adr_i = 32'h10;
    wb.wbs_dat_i = 32'h55555555;
    @(posedge clk);
    #1;
    checks++; if (ram_r_en !== 1'b1) begin errors++; $display("FAIL rmw_read_phase: got r_en %0b want 1", ram_r_en); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (wb.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %0b want 0", wb.wbs_ack_o); end
    checks++; if (ram_wb_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wb_en: got %0b want 0", ram_wb_en); end
    checks++; if (ram_addr !== 8'h0) begin errors++; $display("FAIL rst_mid_addr: got %h want 0", ram_addr); end
    checks++; if (ram_bit_en !== 32'h0) begin errors++; $display("FAIL rst_mid_bit_en: got %h want 0", ram_bit_en); end
    @(negedge clk);
    rst = 1'b0;
    idle_bus();
    @(posedge clk);
    #1;
    checks++; if (wb.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ack_after: got %0b want 0", wb.wbs_ack_o); end
    wb_xfer(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_mem_cleared: got %h want 0", rd); end
  endtask

  task automatic test_alias_back_to_back();
    logic [31:0] rd;
    int lat;
    int acks;
    int bad_dat;
    bit prev_ack;
    int adjacent;
    wb_xfer(1'b1, 32'h400, 4'hF, 32'hCAFEF00D, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL alias_write_lat: got %0d want 2", lat); end
    wb_xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_word0: got %h want cafef00d", rd); end
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = 32'h400;
    acks = 0;
    bad_dat = 0;
    adjacent = 0;
    prev_ack = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o === 1'b1) begin
        acks++;
        if (prev_ack) adjacent++;
        if (wb.wbs_dat_o !== 32'hCAFEF00D) bad_dat++;
      end
      prev_ack = (wb.wbs_ack_o === 1'b1);
    end
    @(negedge clk);
    idle_bus();
    checks++; if (acks !== 3) begin errors++; $display("FAIL b2b_ack_count: got %0d want 3", acks); end
    checks++; if (adjacent !== 0) begin errors++; $display("FAIL b2b_single_ack: got %0d adjacent want 0", adjacent); end
    checks++; if (bad_dat !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad want 0", bad_dat); end
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_sel_masks();
    test_abort();
    test_reset_mid();
    test_alias_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
